ir_queue: RTL and testbench
===========================

IR_QUEUE -- requirements
Module: ir_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queued instruction words; power of two, 2..16.
REQ-002 Parameter AW, default 2, pointer width, equal to log2(DEPTH).
REQ-003 Port clk  input  1  clock; all state changes on rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port clken  input  1  clock enable; gates every state change except reset and flush.
REQ-006 Port dbus  input  36 [0:35]  instruction word from memory.
REQ-007 Port load  input  1  push dbus into the queue.
REQ-008 Port ready  output 1  queue can accept load this cycle.
REQ-009 Port next  input  1  consume the current instruction and advance.
REQ-010 Port flush  input  1  discard all queued words, for jumps and interrupts.
REQ-011 Port valid  output 1  current instruction fields are meaningful.
REQ-012 Port ir  output 9 [0:8]  opcode, dbus[0:8] of the head word.
REQ-013 Port ac  output 4 [0:3]  AC select, dbus[9:12].
REQ-014 Port ind  output 1  indirect bit, dbus[13].
REQ-015 Port xr  output 4 [0:3]  index register, dbus[14:17].
REQ-016 Port y  output 18 [0:17]  address field, dbus[18:35].
REQ-017 Port count  output AW+1  number of stored words, 0..DEPTH.

Function
REQ-018 Storage SHALL be a circular buffer of DEPTH 36-bit words with read pointer, write pointer and count; pointers wrap modulo DEPTH.
REQ-019 ready SHALL equal (count < DEPTH) or (next and valid); it is combinational.
REQ-020 A load with ready=1 and clken=1 SHALL write dbus at the write pointer and increment it.
REQ-021 A load with ready=0 SHALL be ignored; no state change and no overwrite.
REQ-022 valid SHALL equal (count != 0); ir/ac/ind/xr/y SHALL decode the head word combinationally from the registered storage.
REQ-023 When the queue is empty, ir/ac/ind/xr/y SHALL be all zero; stale data is never presented.
REQ-024 next with valid=1 and clken=1 SHALL increment the read pointer; next with valid=0 SHALL be ignored.
REQ-025 load into an empty queue SHALL make valid=1 on the following cycle; minimum latency is 1 clock and there is no same-cycle bypass.
REQ-026 Simultaneous accepted load and next SHALL leave count unchanged, including when the queue is full.
REQ-027 count SHALL change by +1 for an accepted load alone, by -1 for an accepted next alone, and SHALL never leave 0..DEPTH.
REQ-028 flush SHALL take effect regardless of clken and SHALL set both pointers and count to 0 on that edge.
REQ-029 flush SHALL have priority over a load or next in the same cycle; the load word is discarded.
REQ-030 Storage contents need not be cleared by flush or reset; only the pointers and count are cleared.

Reset
REQ-031 On rst, the read pointer, write pointer and count SHALL be 0; valid=0, ir=0, ac=0, ind=0, xr=0, y=0.
REQ-032 Because count resets to 0, ready SHALL be 1 on reset.
REQ-033 rst asserted mid-operation SHALL override load, next, flush and clken immediately and asynchronously.

Structure
REQ-034 Field bit positions (opcode 0:8, AC 9:12, I 13, X 14:17, Y 18:35) SHALL be localparams in the shared ks10 cpu package, for reuse by the decoder.
REQ-035 Field decode SHALL be a separate combinational sub-module, ir_fields, taking a 36-bit word and producing ir/ac/ind/xr/y.
REQ-036 Storage SHALL be inferable as distributed RAM: no reset on the array, with a single write port and an asynchronous read port.

Verification
REQ-037 Reset, then load dbus=0o254000_001000 -> one cycle later: valid=1, ir=0o254, ac=0, ind=0, xr=0, y=0o001000, count=1.
REQ-038 Four loads with DEPTH=4 -> count=4, ready=0; a fifth load is ignored; four nexts return the words in order, then valid=0 and the outputs are zero.
REQ-039 Full queue with load and next in the same cycle -> count stays at 4, the head advances, and the new word appears last; pointers wrap correctly over 3 further cycles.
REQ-040 Three queued words, with flush, load and next asserted together while clken=0 -> next cycle: count=0, valid=0, and the load word is lost.
REQ-041 Toggle clken=0 while load/next are held -> no change in count or outputs; restoring clken=1 resumes operation.
REQ-042 Assert rst asynchronously between clock edges with count=2 -> valid=0 and count=0 before the next edge.

Source files
------------

// File: rtl/ks10_cpu_pkg.sv
// ks10_cpu_pkg: KS10 instruction word field positions, shared by the instruction queue and the decoder.
package ks10_cpu_pkg;
  localparam int WORD_W = 36;
  localparam int OP_L = 0;
  localparam int OP_R = 8;
  localparam int AC_L = 9;
  localparam int AC_R = 12;
  localparam int I_BIT = 13;
  localparam int X_L = 14;
  localparam int X_R = 17;
  localparam int Y_L = 18;
  localparam int Y_R = 35;
  typedef logic [0:WORD_W-1] word_t;
endpackage

// File: rtl/ir_fields.sv
// ir_fields: splits a 36-bit KS10 instruction word into opcode, AC, I, X and Y fields.
module ir_fields
  import ks10_cpu_pkg::*;
(
  input  word_t      i_word,
  output logic [0:8]  o_ir,
  output logic [0:3]  o_ac,
  output logic        o_ind,
  output logic [0:3]  o_xr,
  output logic [0:17] o_y
);
  assign o_ir  = i_word[OP_L:OP_R];
  assign o_ac  = i_word[AC_L:AC_R];
  assign o_ind = i_word[I_BIT];
  assign o_xr  = i_word[X_L:X_R];
  assign o_y   = i_word[Y_L:Y_R];
endmodule

// File: rtl/ir_queue.sv
// ir_queue: circular prefetch queue of instruction words with combinational decode of the head word.
module ir_queue
  import ks10_cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clken,
  input  word_t       dbus,
  input  logic        load,
  output logic        ready,
  input  logic        next,
  input  logic        flush,
  output logic        valid,
  output logic [0:8]  ir,
  output logic [0:3]  ac,
  output logic        ind,
  output logic [0:3]  xr,
  output logic [0:17] y,
  output logic [AW:0] count
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  word_t          r_mem [DEPTH];
  logic [AW-1:0]  r_rd;
  logic [AW-1:0]  r_wr;
  logic [AW:0]    r_cnt;
  logic           w_push;
  logic           w_pop;
  word_t          w_head;
  assign valid  = r_cnt != '0;
  assign ready  = (r_cnt < FULL) || (next && valid);
  assign w_push = clken && load && ready;
  assign w_pop  = clken && next && valid;
  assign count  = r_cnt;
  // Empty queue presents zeros so stale storage never reaches the decoder.
  assign w_head = valid ? r_mem[r_rd] : '0;
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr] <= dbus;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  ir_fields u_fields (
    .i_word (w_head),
    .o_ir   (ir),
    .o_ac   (ac),
    .o_ind  (ind),
    .o_xr   (xr),
    .o_y    (y)
  );
endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: randomized and directed checks of ir_queue against a queue-based reference model.
module tb_ir_queue;
  localparam int DEPTH = 4;
  logic        clk = 0;
  logic        rst = 1;
  logic        clken = 0;
  logic [0:35] dbus = '0;
  logic        load = 0;
  logic        next = 0;
  logic        flush = 0;
  logic        ready;
  logic        valid;
  logic [0:8]  ir;
  logic [0:3]  ac;
  logic        ind;
  logic [0:3]  xr;
  logic [0:17] y;
  logic [2:0]  count;
  logic [39:0] obs;
  logic [35:0] mq[$];
  int n_tests = 0;
  int n_fail = 0;

  ir_queue #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .rst(rst), .clken(clken), .dbus(dbus), .load(load), .ready(ready),
    .next(next), .flush(flush), .valid(valid), .ir(ir), .ac(ac), .ind(ind),
    .xr(xr), .y(y), .count(count)
  );

  always #5 clk = ~clk;
  assign obs = {valid, count, ir, ac, ind, xr, y};

  // Expected {valid, count, head word}; the head word's bits line up with ir|ac|ind|xr|y.
  function automatic logic [39:0] exp_out();
    if (mq.size() == 0) return '0;
    return {1'b1, 3'(mq.size()), mq[0]};
  endfunction

  function automatic bit exp_ready();
    return mq.size() < DEPTH || (next && mq.size() != 0);
  endfunction

  task automatic drive(input logic l, input logic n, input logic f, input logic ce, input logic [35:0] d);
    @(negedge clk);
    load = l; next = n; flush = f; clken = ce; dbus = d;
    #1;
  endtask

  task automatic tick();
    int sz;
    bit an;
    @(posedge clk);
    sz = mq.size();
    if (flush) mq.delete();
    else if (clken) begin
      an = next && sz != 0;
      if (an) void'(mq.pop_front());
      if (load && (sz < DEPTH || an)) mq.push_back(dbus);
    end
    #1;
  endtask

  function automatic logic [35:0] rw();
    return {4'($urandom), 32'($urandom)};
  endfunction

  task automatic test_reset();
    #12;
    if (obs !== 40'h0) begin n_fail++; $display("FAIL reset_out: got %h want 0", obs); end
    n_tests++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_tests++;
    rst = 0;
  endtask

  task automatic test_basic();
    drive(1, 0, 0, 1, 36'o254000001000);
    if (valid !== 1'b0) begin n_fail++; $display("FAIL no_bypass: got valid=%b want 0", valid); end
    n_tests++;
    tick();
    if (obs !== exp_out()) begin n_fail++; $display("FAIL basic_load: got %h want %h", obs, exp_out()); end
    n_tests++;
    if (ir !== 9'o254 || y !== 18'o001000 || count !== 3'd1) begin
      n_fail++; $display("FAIL basic_fields: got ir=%o y=%o count=%0d want 254 1000 1", ir, y, count);
    end
    n_tests++;
  endtask

  task automatic test_fill();
    drive(0, 0, 1, 0, '0); tick();
    for (int i = 0; i < 4; i++) begin drive(1, 0, 0, 1, rw()); tick(); end
    if (count !== 3'd4 || ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got count=%0d ready=%b want 4 0", count, ready); end
    n_tests++;
    drive(1, 0, 0, 1, rw()); tick();
    if (obs !== exp_out()) begin n_fail++; $display("FAIL fill_overflow: got %h want %h", obs, exp_out()); end
    n_tests++;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 1, '0); tick();
      if (obs !== exp_out()) begin n_fail++; $display("FAIL fill_drain%0d: got %h want %h", i, obs, exp_out()); end
      n_tests++;
    end
    if (obs !== 40'h0) begin n_fail++; $display("FAIL fill_empty: got %h want 0", obs); end
    n_tests++;
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 4; i++) begin drive(1, 0, 0, 1, rw()); tick(); end
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 1, rw());
      if (ready !== 1'b1) begin n_fail++; $display("FAIL simul_ready%0d: got %b want 1", i, ready); end
      n_tests++;
      tick();
      if (obs !== exp_out()) begin n_fail++; $display("FAIL simul%0d: got %h want %h", i, obs, exp_out()); end
      n_tests++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 1, '0); tick();
      if (obs !== exp_out()) begin n_fail++; $display("FAIL simul_order%0d: got %h want %h", i, obs, exp_out()); end
      n_tests++;
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin drive(1, 0, 0, 1, rw()); tick(); end
    drive(1, 1, 1, 0, rw()); tick();
    if (obs !== 40'h0 || mq.size() != 0) begin n_fail++; $display("FAIL flush: got %h want 0", obs); end
    n_tests++;
  endtask

  task automatic test_clken();
    for (int i = 0; i < 2; i++) begin drive(1, 0, 0, 1, rw()); tick(); end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, rw()); tick();
      if (obs !== exp_out() || count !== 3'd2) begin n_fail++; $display("FAIL clken_hold%0d: got %h want %h", i, obs, exp_out()); end
      n_tests++;
    end
    drive(0, 1, 0, 1, '0); tick();
    if (obs !== exp_out()) begin n_fail++; $display("FAIL clken_resume: got %h want %h", obs, exp_out()); end
    n_tests++;
  endtask

  task automatic test_async_rst();
    drive(0, 0, 1, 1, '0); tick();
    for (int i = 0; i < 2; i++) begin drive(1, 0, 0, 1, rw()); tick(); end
    drive(1, 0, 0, 1, rw());
    #1 rst = 1;
    #1;
    if (valid !== 1'b0 || count !== 3'd0 || obs !== 40'h0) begin
      n_fail++; $display("FAIL async_rst: got valid=%b count=%0d want 0 0", valid, count);
    end
    n_tests++;
    mq.delete();
    rst = 0;
    load = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 1'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 4) != 0, rw());
      if (ready !== exp_ready()) begin n_fail++; $display("FAIL rand_ready%0d: got %b want %b", i, ready, exp_ready()); end
      n_tests++;
      tick();
      if (obs !== exp_out()) begin n_fail++; $display("FAIL rand_out%0d: got %h want %h", i, obs, exp_out()); end
      n_tests++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_full_simul();
    test_flush();
    test_clken();
    test_async_rst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
